ram_ws: RTL and testbench
=========================

// Module: ram_ws
// PURPOSE
//  Parametrised synchronous RAM for the Altair 680 memory map, next generation of the fixed 16K x 8 store.
//  Adds: configurable width/depth, chip-select/ready handshake with programmable wait states,
//  a write-protected address window, and an optional zero-fill sweep after reset.
//  Sits on the shared tristate CPU data bus alongside ROM and I/O; the address decoder drives sel_in.
// PARAMETERS
//  ADDR_WIDTH     14   address bits; DEPTH = 1<<ADDR_WIDTH words
//  DATA_WIDTH     8    word/bus width
//  WAIT_STATES    0    extra cycles between request latch and access (0..15)
//  CLEAR_ON_RESET 1    1: zero-fill all words after reset release; 0: contents undefined
//  PROT_LO        0    first word of write-protect window (inclusive)
//  PROT_HI        0    last word of write-protect window (inclusive); PROT_HI<PROT_LO = empty window
// PORTS
//  clk_in      in    1           clock, all state updates on rising edge
//  rst_n_in    in    1           Reset is asynchronous, active-low; one clock.
//  sel_in      in    1           request; held with addr/write/data until ready_out seen
//  write_in    in    1           1 = write, 0 = read; qualified by sel_in
//  addr_in     in    ADDR_WIDTH  word address
//  bus_io      inout DATA_WIDTH  write data in / read data out; Z when not driving
//  prot_en_in  in    1           1 = enforce write-protect window
//  ready_out   out   1           one-cycle pulse: access complete, read data valid on bus_io
//  busy_out    out   1           1 during zero-fill sweep
//  wp_err_out  out   1           one-cycle pulse with ready_out when a write was suppressed
// BEHAVIOUR
//  Reset (async assert): state<=CLEAR if CLEAR_ON_RESET else IDLE; ready_out=0, wp_err_out=0,
//   busy_out=CLEAR_ON_RESET, read buffer=0, clear counter=0, wait counter=0; bus_io Z immediately.
//   Memory array is not reset except by the sweep. A reset mid-access abandons it; an in-flight write is not committed.
//  States: CLEAR, IDLE, WAIT, DONE, HOLD.
//  CLEAR: each edge writes 0 to word clr_cnt and increments it. After word DEPTH-1, go IDLE and drop busy_out.
//   Sweep takes DEPTH cycles. sel_in is ignored (not latched) while in CLEAR; the master simply waits for ready_out.
//  IDLE: on an edge with sel_in=1, latch addr_in, write_in, bus_io; wait cnt<=WAIT_STATES; go WAIT.
//  WAIT: on each edge, if cnt!=0 then cnt<=cnt-1.
//   Otherwise perform the access, set ready_out<=1 and go DONE:
//   - read: buffer<=mem[addr_q].
//   - write: mem[addr_q]<=data_q and buffer<=data_q, unless prot_en_in=1 and PROT_LO<=addr_q<=PROT_HI.
//     In that case memory is unchanged, buffer is unchanged and wp_err_out<=1.
//   prot_en_in is sampled at the access edge, not at latch.
//  Latency: request sampled at edge k gives ready_out high in the cycle after edge k+1+WAIT_STATES.
//   With WAIT_STATES=0 this is 2 cycles.
//  DONE: ready_out and wp_err_out clear on the next edge. Go HOLD if sel_in=1, else IDLE.
//  HOLD: stay until sel_in=0, then IDLE. One request yields exactly one access, however long sel_in is held.
//  bus_io driven = buffer iff sel_in=1 && write_in=0 && state in {DONE, HOLD}; otherwise Z.
//   The block never drives the bus during CLEAR, IDLE, WAIT or any write.
//  sel_in dropping during WAIT does not abort the access: it completes, ready_out pulses, then IDLE.
//  Back-to-back: a new request needs sel_in low for at least one edge in HOLD/DONE, then is sampled in IDLE.
//  Wait counter width: $clog2(WAIT_STATES+1), minimum 1. Clear counter: ADDR_WIDTH+1 bits; no wrap re-entry.
// TESTING
//  1 CLEAR_ON_RESET=1, ADDR_WIDTH=4: release reset -> busy_out high for exactly 16 cycles; all reads return 0x00.
//  2 WAIT_STATES=0: write 0xA5 @0x003, drop sel, read @0x003 -> ready_out 2 cycles after sel sampled, bus_io=0xA5.
//    bus_io is Z outside DONE/HOLD.
//  3 WAIT_STATES=3: read -> ready_out exactly 5 cycles after request edge; sel held 20 cycles -> single ready pulse.
//  4 PROT_LO=8, PROT_HI=11, prot_en_in=1: write 0x5A @0x009 -> ready+wp_err pulse, readback keeps old value.
//    Same write with prot_en_in=0 -> readback 0x5A, no wp_err. Write @0x00C -> stored.
//  5 Assert rst_n_in during WAIT of a write 0x77 @0x002 -> outputs reset at once, bus Z.
//    After the sweep (CLEAR_ON_RESET=1) @0x002 reads 0x00.
//  6 Request asserted during CLEAR -> no ready until sweep ends; then served normally with the correct latency.

Source files
------------

// File: rtl/ram_ws.sv
// ram_ws: parametrised synchronous word RAM for the Altair 680 memory map.
// Single-port store on a shared tristate data bus. The bus master holds
// sel_in/write_in/addr_in/bus_io until ready_out. The access completes after
// WAIT_STATES extra cycles. Writes into [PROT_LO, PROT_HI] are refused while
// prot_en_in is high. An optional zero-fill sweep runs after reset.
module ram_ws #(
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 8,
    parameter int WAIT_STATES    = 0,
    parameter int CLEAR_ON_RESET = 1,
    parameter int PROT_LO        = 0,
    parameter int PROT_HI        = 0
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  sel_in,
    input  logic                  write_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    inout  wire  [DATA_WIDTH-1:0] bus_io,
    input  logic                  prot_en_in,
    output logic                  ready_out,
    output logic                  busy_out,
    output logic                  wp_err_out
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WAIT,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    latch;
    logic                    access;
    logic                    prot_hit;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]        wait_cnt;
    logic [ADDR_WIDTH:0]     clr_cnt;
    logic [DATA_WIDTH-1:0]   buffer;
    logic                    ready_q;
    logic                    wp_err_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // State register; reset lands in the sweep or directly in idle.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the one-cycle latch/access strobes.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        access    = 1'b0;
        case (state)
            ST_CLEAR: begin
                if (clr_cnt == (ADDR_WIDTH + 1)'(DEPTH - 1)) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (sel_in) begin
                    latch     = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    access    = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = sel_in ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (!sel_in) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Protection is judged on the latched address but on the live enable at the access edge.
    always_comb begin
        prot_hit  = prot_en_in && (int'(addr_q) >= PROT_LO) && (int'(addr_q) <= PROT_HI);
        mem_we    = rst_n_in && ((state == ST_CLEAR) || (access && write_q && !prot_hit));
        mem_addr  = (state == ST_CLEAR) ? clr_cnt[ADDR_WIDTH-1:0] : addr_q;
        mem_wdata = (state == ST_CLEAR) ? '0 : data_q;
    end

    // Storage array: deliberately unreset, only the sweep clears it.
    always_ff @(posedge clk_in) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Request latch, wait/sweep counters, read buffer and handshake pulses.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_q   <= '0;
            write_q  <= 1'b0;
            data_q   <= '0;
            wait_cnt <= '0;
            clr_cnt  <= '0;
            buffer   <= '0;
            ready_q  <= 1'b0;
            wp_err_q <= 1'b0;
        end else begin
            ready_q  <= 1'b0;
            wp_err_q <= 1'b0;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + (ADDR_WIDTH + 1)'(1);
            end
            if (latch) begin
                addr_q   <= addr_in;
                write_q  <= write_in;
                data_q   <= bus_io;
                wait_cnt <= CNT_W'(WAIT_STATES);
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - CNT_W'(1);
            end
            if (access) begin
                ready_q <= 1'b1;
                if (!write_q) begin
                    buffer <= mem[addr_q];
                end else if (prot_hit) begin
                    wp_err_q <= 1'b1;
                end else begin
                    buffer <= data_q;
                end
            end
        end
    end

    assign busy_out   = (state == ST_CLEAR);
    assign ready_out  = ready_q;
    assign wp_err_out = wp_err_q;
    assign bus_io     = (sel_in && !write_in && ((state == ST_DONE) || (state == ST_HOLD)))
                        ? buffer : 'z;

endmodule

// File: tb/tb_ram_ws.sv
// tb_ram_ws: two ram_ws instances share one request stream. Instance a uses
// zero wait states and instance b uses three. Both have a 16-word array and
// write-protect window 8..11. Each instance has its own scoreboard queue.
module tb_ram_ws;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk_in = 1'b0;
    logic          rst_n_in;
    logic          sel_in;
    logic          write_in;
    logic          prot_en_in;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] tb_data;
    logic          tb_drv;
    wire  [DW-1:0] bus_a;
    wire  [DW-1:0] bus_b;
    logic          ready_a, busy_a, wp_a;
    logic          ready_b, busy_b, wp_b;

    assign bus_a = tb_drv ? tb_data : 'z;
    assign bus_b = tb_drv ? tb_data : 'z;

    always #5 clk_in = ~clk_in;

    ram_ws #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(0), .CLEAR_ON_RESET(1),
             .PROT_LO(8), .PROT_HI(11)) dut_a (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .sel_in(sel_in), .write_in(write_in),
        .addr_in(addr_in), .bus_io(bus_a), .prot_en_in(prot_en_in),
        .ready_out(ready_a), .busy_out(busy_a), .wp_err_out(wp_a));

    ram_ws #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(3), .CLEAR_ON_RESET(1),
             .PROT_LO(8), .PROT_HI(11)) dut_b (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .sel_in(sel_in), .write_in(write_in),
        .addr_in(addr_in), .bus_io(bus_b), .prot_en_in(prot_en_in),
        .ready_out(ready_b), .busy_out(busy_b), .wp_err_out(wp_b));

    typedef struct {
        bit          wr;
        logic [DW-1:0] data;
        bit          err;
    } sb_t;

    typedef struct {
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        bit            prot;
        int            hold;
        logic [DW-1:0] exp;
        bit            err;
    } vec_t;

    sb_t  q_a[$];
    sb_t  q_b[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // A released bus reads as Z, or as 0 on a two-state simulator.
    task automatic chk_rel(input string name, input logic [DW-1:0] v);
        n_checks++;
        if ((v === '0) || (v === 'z)) n_pass++;
        else $display("FAIL %s: bus %h expected released at %0t", name, v, $time);
    endtask

    task automatic mon(input int id, input int i, input bit wr, inout bit done);
        logic          r, e;
        logic [DW-1:0] b;
        int            lat;
        bit            empty;
        sb_t           t;
        if (id == 0) begin
            r = ready_a; e = wp_a; b = bus_a; lat = 2; empty = (q_a.size() == 0);
        end else begin
            r = ready_b; e = wp_b; b = bus_b; lat = 5; empty = (q_b.size() == 0);
        end
        if (r) begin
            if (empty || done) begin
                n_checks++;
                $display("FAIL extra_ready dut%0d: ready_out 1 expected 0 at cycle %0d", id, i);
            end else begin
                if (id == 0) t = q_a.pop_front();
                else         t = q_b.pop_front();
                chk($sformatf("latency_dut%0d", id), i, lat);
                chk($sformatf("wp_err_dut%0d", id), e, t.err);
                if (!t.wr) chk($sformatf("rdata_dut%0d", id), b, t.data);
                done = 1'b1;
            end
        end else begin
            chk($sformatf("wp_err_quiet_dut%0d", id), e, 0);
            if (!done && !wr) chk_rel($sformatf("bus_wait_dut%0d", id), b);
        end
    endtask

    // One request held for at least 'hold' cycles; flip>0 raises prot_en_in after that cycle.
    task automatic access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input bit prot, input int hold,
                          input logic [DW-1:0] ea, input bit era,
                          input logic [DW-1:0] eb, input bit erb, input int flip);
        bit da, db;
        int i;
        da = 1'b0; db = 1'b0; i = 0;
        sel_in = 1'b1; write_in = wr; addr_in = a; tb_data = d; tb_drv = wr; prot_en_in = prot;
        q_a.push_back(sb_t'{wr, ea, era});
        q_b.push_back(sb_t'{wr, eb, erb});
        while (!(da && db && i >= hold)) begin
            @(negedge clk_in);
            i++;
            mon(0, i, wr, da);
            mon(1, i, wr, db);
            if (flip != 0 && i == flip) prot_en_in = 1'b1;
            if (i >= 60) begin
                n_checks++;
                $display("FAIL timeout: ready_out not seen (a=%0d b=%0d) expected within 60 cycles", da, db);
                q_a.delete();
                q_b.delete();
                break;
            end
        end
        sel_in = 1'b0; write_in = 1'b0; tb_drv = 1'b0; prot_en_in = 1'b0;
        @(negedge clk_in);
        chk_rel("bus_idle_a", bus_a);
        chk_rel("bus_idle_b", bus_b);
        chk("ready_idle_a", ready_a, 0);
        chk("ready_idle_b", ready_b, 0);
    endtask

    // Reset, release, and time the sweep; optionally with a read waiting throughout it.
    task automatic reset_seq(input bit with_req);
        int bl_a, bl_b, ra, rb, pa, pb;
        bl_a = -1; bl_b = -1; ra = -1; rb = -1; pa = 0; pb = 0;
        rst_n_in = 1'b0; sel_in = 1'b0; write_in = 1'b0; tb_drv = 1'b0; prot_en_in = 1'b0;
        @(negedge clk_in);
        chk("rst_ready_a", ready_a, 0);
        chk("rst_ready_b", ready_b, 0);
        chk("rst_wp_a", wp_a, 0);
        chk("rst_busy_a", busy_a, 1);
        chk("rst_busy_b", busy_b, 1);
        rst_n_in = 1'b1;
        if (with_req) begin
            sel_in = 1'b1; addr_in = 4'h5;
        end
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk_in);
            if (!busy_a && bl_a < 0) bl_a = j;
            if (!busy_b && bl_b < 0) bl_b = j;
            if (ready_a) begin
                pa++;
                if (ra < 0) begin ra = j; chk("sweep_rdata_a", bus_a, 0); end
            end
            if (ready_b) begin
                pb++;
                if (rb < 0) begin rb = j; chk("sweep_rdata_b", bus_b, 0); end
            end
        end
        chk("busy_cycles_a", bl_a, 16);
        chk("busy_cycles_b", bl_b, 16);
        if (with_req) begin
            chk("clear_req_lat_a", ra, 18);
            chk("clear_req_lat_b", rb, 21);
            chk("clear_req_pulses_a", pa, 1);
            chk("clear_req_pulses_b", pb, 1);
        end else begin
            chk("sweep_pulses_a", pa, 0);
            chk("sweep_pulses_b", pb, 0);
        end
        sel_in = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        //            wr    addr   data   prot hold  exp    err
        tbl[0]  = '{1'b1, 4'h3, 8'hA5, 1'b0, 1,  8'h00, 1'b0};
        tbl[1]  = '{1'b0, 4'h3, 8'h00, 1'b0, 1,  8'hA5, 1'b0};
        tbl[2]  = '{1'b0, 4'h5, 8'h00, 1'b0, 20, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 4'h9, 8'h11, 1'b0, 1,  8'h00, 1'b0};
        tbl[4]  = '{1'b1, 4'h9, 8'h5A, 1'b1, 1,  8'h00, 1'b1};
        tbl[5]  = '{1'b0, 4'h9, 8'h00, 1'b1, 1,  8'h11, 1'b0};
        tbl[6]  = '{1'b1, 4'h9, 8'h5A, 1'b0, 1,  8'h00, 1'b0};
        tbl[7]  = '{1'b0, 4'h9, 8'h00, 1'b0, 1,  8'h5A, 1'b0};
        tbl[8]  = '{1'b1, 4'hC, 8'h3C, 1'b1, 1,  8'h00, 1'b0};
        tbl[9]  = '{1'b0, 4'hC, 8'h00, 1'b0, 1,  8'h3C, 1'b0};
        tbl[10] = '{1'b1, 4'h8, 8'hEE, 1'b1, 1,  8'h00, 1'b1};
        tbl[11] = '{1'b1, 4'hB, 8'hEE, 1'b1, 1,  8'h00, 1'b1};
        tbl[12] = '{1'b1, 4'h7, 8'h81, 1'b1, 1,  8'h00, 1'b0};
        tbl[13] = '{1'b0, 4'h8, 8'h00, 1'b0, 1,  8'h00, 1'b0};
        tbl[14] = '{1'b0, 4'hB, 8'h00, 1'b0, 1,  8'h00, 1'b0};
        tbl[15] = '{1'b0, 4'h7, 8'h00, 1'b0, 1,  8'h81, 1'b0};
        tbl[16] = '{1'b0, 4'h3, 8'h00, 1'b1, 1,  8'hA5, 1'b0};
        tbl[17] = '{1'b1, 4'h3, 8'h5A, 1'b1, 8,  8'h00, 1'b0};
        tbl[18] = '{1'b0, 4'h3, 8'h00, 1'b0, 1,  8'h5A, 1'b0};
        tbl[19] = '{1'b1, 4'h2, 8'h44, 1'b0, 1,  8'h00, 1'b0};

        rst_n_in = 1'b0; sel_in = 1'b0; write_in = 1'b0; addr_in = '0;
        tb_data = '0; tb_drv = 1'b0; prot_en_in = 1'b0;
        #1;
        chk("async_rst_ready_a", ready_a, 0);
        chk("async_rst_busy_a", busy_a, 1);
        chk("async_rst_busy_b", busy_b, 1);

        // Sweep with a read pending from the moment reset releases.
        reset_seq(1'b1);

        // Whole array reads zero after the sweep.
        for (int a = 0; a < 16; a++) begin
            access(1'b0, AW'(a), 8'h00, 1'b0, 1, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        end

        for (int k = 0; k < 20; k++) begin
            access(tbl[k].wr, tbl[k].addr, tbl[k].data, tbl[k].prot, tbl[k].hold,
                   tbl[k].exp, tbl[k].err, tbl[k].exp, tbl[k].err, 0);
        end
        access(1'b0, 4'h2, 8'h00, 1'b0, 1, 8'h44, 1'b0, 8'h44, 1'b0, 0);

        // prot_en_in rises after instance a has accessed but before instance b does.
        access(1'b1, 4'h9, 8'h99, 1'b0, 1, 8'h00, 1'b0, 8'h00, 1'b1, 2);
        access(1'b0, 4'h9, 8'h00, 1'b0, 1, 8'h99, 1'b0, 8'h5A, 1'b0, 0);

        // Reset lands while both instances sit in WAIT on a write.
        sel_in = 1'b1; write_in = 1'b1; addr_in = 4'h2; tb_data = 8'h77; tb_drv = 1'b1;
        @(negedge clk_in);
        rst_n_in = 1'b0;
        #1;
        chk("midrst_ready_a", ready_a, 0);
        chk("midrst_ready_b", ready_b, 0);
        chk("midrst_wp_b", wp_b, 0);
        chk("midrst_busy_a", busy_a, 1);
        chk("midrst_busy_b", busy_b, 1);
        write_in = 1'b0; tb_drv = 1'b0;
        #1;
        chk_rel("midrst_bus_a", bus_a);
        chk_rel("midrst_bus_b", bus_b);
        sel_in = 1'b0;
        reset_seq(1'b0);

        access(1'b0, 4'h2, 8'h00, 1'b0, 1, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        access(1'b0, 4'h3, 8'h00, 1'b0, 1, 8'h00, 1'b0, 8'h00, 1'b0, 0);
        access(1'b0, 4'h9, 8'h00, 1'b0, 1, 8'h00, 1'b0, 8'h00, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
